// File: rtl/lpc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lpc_pkg
// Description : Shared definitions for the LPC capture path: cycle type codes,
//               record layout and the record-to-byte mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package lpc_pkg;

  localparam logic [1:0] CT_IO     = 2'b00;
  localparam logic [1:0] CT_MEM    = 2'b01;
  localparam int         REC_BYTES = 6;
  localparam logic [2:0] REC_MARK  = 3'b101;

  // One captured cycle as it sits in the FIFO (45 bits)
  typedef struct packed {
    logic [3:0]  cyctype_dir;
    logic        drop;
    logic [31:0] addr;
    logic [7:0]  data;
  } lpc_rec_t;

  // Byte idx of the on-the-wire record: header, address MSB first, data
  function automatic logic [7:0] rec_byte(input lpc_rec_t r, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {r.cyctype_dir, r.drop, REC_MARK};
      3'd1:    b = r.addr[31:24];
      3'd2:    b = r.addr[23:16];
      3'd3:    b = r.addr[15:8];
      3'd4:    b = r.addr[7:0];
      default: b = r.data;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lpc_rec_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lpc_rec_fifo
// Description : Show-ahead synchronous FIFO of capture records. The head entry
//               is visible on o_head whenever o_empty is low.
// Revision    : 1.0 - initial release
// ============================================================================
module lpc_rec_fifo
  import lpc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          lpc_clock,
  input  logic                          reset,
  input  logic                          i_push,
  input  lpc_rec_t                      i_data,
  input  logic                          i_pop,
  output lpc_rec_t                      o_head,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  lpc_rec_t       r_mem [FIFO_DEPTH];
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic [AW:0]    w_level;
  logic           w_push;
  logic           w_pop;

  // Extra pointer bit distinguishes full from empty
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign o_level = w_level;
  assign o_full  = (w_level == (AW+1)'(FIFO_DEPTH));
  assign o_empty = (w_level == '0);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Guard against writes when full and reads when empty
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage array, no reset so it maps onto plain registers/RAM
  always_ff @(posedge lpc_clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // Read/write pointer update
  always_ff @(posedge lpc_clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lpc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lpc_capture_ctrl
// Description : Filters decoded LPC cycles, queues accepted ones as 6-byte
//               records and drains them over a byte-wide valid/ready link.
//               Records dropped on a full FIFO are counted and flagged on the
//               next record that does get queued.
// Revision    : 1.0 - initial release
// ============================================================================
module lpc_capture_ctrl
  import lpc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          lpc_clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [3:0]                    in_cyctype_dir,
  input  logic [31:0]                   in_addr,
  input  logic [7:0]                    in_data,
  input  logic                          cfg_enable,
  input  logic                          cfg_io_en,
  input  logic                          cfg_mem_en,
  input  logic [31:0]                   cfg_addr_base,
  input  logic [31:0]                   cfg_addr_mask,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              overflow_count,
  output logic                          busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]       r_state;
  lpc_rec_t         r_rec;
  logic [2:0]       r_idx;
  logic             r_drop_pending;
  logic [CNT_W-1:0] r_ovf_cnt;

  logic             w_type_ok;
  logic             w_addr_ok;
  logic             w_accept;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_ovf;
  logic             w_pop;
  logic             w_last;
  lpc_rec_t         w_new_rec;
  lpc_rec_t         w_head;

  // Cycle filter: type enable and masked address window
  assign w_type_ok = ((in_cyctype_dir[3:2] == CT_IO)  & cfg_io_en) |
                     ((in_cyctype_dir[3:2] == CT_MEM) & cfg_mem_en);
  assign w_addr_ok = (((in_addr ^ cfg_addr_base) & cfg_addr_mask) == 32'h0);
  assign w_accept  = in_valid & cfg_enable & w_type_ok & w_addr_ok;

  // Fullness is taken before this edge's pop, so a pop never frees room for
  // the cycle arriving on the same edge
  assign w_push = w_accept & ~w_full;
  assign w_ovf  = w_accept &  w_full;

  assign w_new_rec = '{cyctype_dir: in_cyctype_dir, drop: r_drop_pending,
                       addr: in_addr, data: in_data};

  assign w_last = (r_idx == 3'(REC_BYTES - 1));
  assign w_pop  = ~w_empty & ((r_state == S_IDLE) |
                              ((r_state == S_SEND) & tx_ready & w_last));

  lpc_rec_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .lpc_clock (lpc_clock),
    .reset     (reset),
    .i_push    (w_push),
    .i_data    (w_new_rec),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (fifo_level)
  );

  // Overflow counter (saturating) and sticky drop flag for the next record
  always_ff @(posedge lpc_clock) begin
    if (reset) begin
      r_ovf_cnt      <= '0;
      r_drop_pending <= 1'b0;
    end else begin
      if (w_ovf && (r_ovf_cnt != {CNT_W{1'b1}})) r_ovf_cnt <= r_ovf_cnt + 1'b1;
      if (w_ovf)       r_drop_pending <= 1'b1;
      else if (w_push) r_drop_pending <= 1'b0;
    end
  end

  // Serializer: load head on pop, step through bytes on each accepted transfer
  always_ff @(posedge lpc_clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rec   <= '0;
      r_idx   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_rec   <= w_head;
            r_idx   <= 3'd0;
            r_state <= S_SEND;
          end
        end
        default: begin
          if (tx_ready) begin
            if (!w_last) begin
              r_idx <= r_idx + 3'd1;
            end else if (!w_empty) begin
              r_rec <= w_head;
              r_idx <= 3'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign tx_valid       = (r_state == S_SEND);
  assign tx_data        = tx_valid ? rec_byte(r_rec, r_idx) : 8'h00;
  assign overflow_count = r_ovf_cnt;
  assign busy           = tx_valid | ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_lpc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lpc_capture_ctrl
// Description : Scoreboard bench for lpc_capture_ctrl. Stimulus pushes the
//               expected record bytes; a monitor thread pops and compares on
//               every link transfer and watches handshake stability.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lpc_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_cyctype_dir;
  logic [31:0] in_addr;
  logic [7:0]  in_data;
  logic        cfg_enable, cfg_io_en, cfg_mem_en;
  logic [31:0] cfg_addr_base, cfg_addr_mask;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  fifo_level;
  logic [15:0] overflow_count;
  logic        busy;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  lpc_capture_ctrl #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .lpc_clock      (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_cyctype_dir (in_cyctype_dir),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .cfg_enable     (cfg_enable),
    .cfg_io_en      (cfg_io_en),
    .cfg_mem_en     (cfg_mem_en),
    .cfg_addr_base  (cfg_addr_base),
    .cfg_addr_mask  (cfg_addr_mask),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .fifo_level     (fifo_level),
    .overflow_count (overflow_count),
    .busy           (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rec(input logic [7:0] b0, input logic [31:0] a, input logic [7:0] d);
    exp_q.push_back(b0);
    exp_q.push_back(a[31:24]);
    exp_q.push_back(a[23:16]);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(d);
  endtask

  task automatic drive_cycle(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] d);
    in_valid       = 1'b1;
    in_cyctype_dir = ct;
    in_addr        = a;
    in_data        = d;
    tick();
    in_valid       = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < max_cyc) begin
      tick();
      k++;
    end
    chk("drain_in_time", 32'(k < max_cyc), 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_cyctype_dir = 4'h0; in_addr = 32'h0; in_data = 8'h0;
    cfg_enable = 1'b0; cfg_io_en = 1'b0; cfg_mem_en = 1'b0;
    cfg_addr_base = 32'h0; cfg_addr_mask = 32'h0; tx_ready = 1'b0;

    fork
      // Monitor: compare each transferred byte, check stall stability
      begin : mon
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        logic [7:0] e;
        forever begin
          @(negedge clk);
          if (reset) begin
            prev_stall = 1'b0;
          end else begin
            if (prev_stall) begin
              chk("stall_valid_held", 32'(tx_valid), 32'd1);
              chk("stall_data_held", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
              if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_byte actual=%0h required=none", tx_data);
              end else begin
                e = exp_q.pop_front();
                chk("tx_byte", 32'(tx_data), 32'(e));
              end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
          end
        end
      end
      // Watchdog
      begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // 1: IO write, mask 0, latency
    cfg_enable = 1'b1; cfg_io_en = 1'b1; cfg_mem_en = 1'b0;
    cfg_addr_base = 32'h0; cfg_addr_mask = 32'h0; tx_ready = 1'b1;
    push_rec(8'h25, 32'h0000_0080, 8'h5A);
    drive_cycle(4'b0010, 32'h0000_0080, 8'h5A);
    chk("lat_edge_n_valid", 32'(tx_valid), 32'd0);
    tick();
    chk("lat_edge_n1_valid", 32'(tx_valid), 32'd1);
    chk("lat_edge_n1_b0", 32'(tx_data), 32'h25);
    wait_drain(50);

    // 2: MEM read in window, then outside window and a DMA cycle
    cfg_mem_en = 1'b1; cfg_addr_base = 32'hFFFF_0000; cfg_addr_mask = 32'hFFFF_0000;
    push_rec(8'h45, 32'hFFFF_FFF0, 8'h3C);
    drive_cycle(4'b0100, 32'hFFFF_FFF0, 8'h3C);
    wait_drain(50);
    drive_cycle(4'b0100, 32'h000C_0000, 8'h77);
    drive_cycle(4'b1000, 32'hFFFF_1234, 8'h11);
    tick(); tick(); tick();
    chk("filtered_busy", 32'(busy), 32'd0);
    chk("filtered_ovf", 32'(overflow_count), 32'd0);

    // 3: overflow with a stalled link
    cfg_addr_base = 32'h0; cfg_addr_mask = 32'h0; tx_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i <= 9) push_rec(8'h25, 32'h100 + 32'(i), 8'(i));
      drive_cycle(4'b0010, 32'h100 + 32'(i), 8'(i));
    end
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_count", 32'(overflow_count), 32'd1);
    chk("ovf_busy", 32'(busy), 32'd1);
    chk("ovf_stalled_b0", 32'(tx_data), 32'h25);
    tx_ready = 1'b1;
    wait_drain(200);
    push_rec(8'h2D, 32'h0000_0211, 8'hB1);
    drive_cycle(4'b0010, 32'h0000_0211, 8'hB1);
    push_rec(8'h25, 32'h0000_0212, 8'hB2);
    drive_cycle(4'b0010, 32'h0000_0212, 8'hB2);
    wait_drain(100);

    // 4: random link backpressure
    for (int i = 0; i < 6; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      push_rec(8'h25, {8'(i), 8'hC3, 8'(i * 17), 8'h3C}, 8'(8'hE0 + i));
      drive_cycle(4'b0010, {8'(i), 8'hC3, 8'(i * 17), 8'h3C}, 8'(8'hE0 + i));
      tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
      tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    tx_ready = 1'b1;
    wait_drain(100);
    chk("random_ovf_unchanged", 32'(overflow_count), 32'd1);

    // 5: two records back to back, no bubble
    tx_ready = 1'b0;
    push_rec(8'h45, 32'h1234_5678, 8'h9A);
    drive_cycle(4'b0100, 32'h1234_5678, 8'h9A);
    push_rec(8'h65, 32'h8765_4321, 8'hA9);
    drive_cycle(4'b0110, 32'h8765_4321, 8'hA9);
    tick();
    tx_ready = 1'b1;
    begin
      int run = 0;
      while (tx_valid && run < 20) begin
        run++;
        tick();
      end
      chk("b2b_valid_run", 32'(run), 32'd12);
    end
    wait_drain(50);

    // 6: reset in the middle of a record
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_rec(8'h25, 32'h0000_0300 + 32'(i), 8'(i));
      drive_cycle(4'b0010, 32'h0000_0300 + 32'(i), 8'(i));
    end
    chk("mid_level", 32'(fifo_level), 32'd3);
    tx_ready = 1'b1;
    tick(); tick();
    chk("mid_third_byte", 32'(tx_data), 32'h00);
    tx_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("mid_rst_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ovf", 32'(overflow_count), 32'd0);
    tx_ready = 1'b1;
    tick(); tick(); tick();
    chk("mid_rst_no_resend", 32'(busy), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
